// File: rtl/clause_scheduler_pkg.sv
// Shared widths and FSM state type for the clause scheduler.
package clause_scheduler_pkg;

  localparam int unsigned NUM_VARS = 2;
  localparam int unsigned VAR_W    = 8;

  // A clause carries one coefficient per variable plus a constant term.
  localparam int unsigned CW = (NUM_VARS + 1) * VAR_W;
  localparam int unsigned AW = NUM_VARS * VAR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRIVE,
    S_EVAL,
    S_DONE
  } state_e;

endpackage

// File: rtl/clause_scheduler_if.sv
// Requester/memory/checker-facing bundle of the clause scheduler.
interface clause_scheduler_if
    import clause_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 3
) ();
    logic              in_enable;
    logic              in_start;
    logic [AW-1:0]     in_current_assignment;
    logic [ADDR_W-1:0] out_clause_addr;
    logic [2*CW-1:0]   in_clause_data;
    logic [CW-1:0]     out_coefficients_clause1;
    logic [CW-1:0]     out_coefficients_clause2;
    logic [AW-1:0]     out_current_assignment;
    logic [1:0]        in_flag;
    logic              out_busy;
    logic              out_done;
    logic [CNT_W-1:0]  out_violations;
    logic              out_all_sat;

    modport slave (
        input  in_enable, in_start, in_current_assignment, in_clause_data, in_flag,
        output out_clause_addr, out_coefficients_clause1, out_coefficients_clause2,
               out_current_assignment, out_busy, out_done, out_violations, out_all_sat
    );

    modport master (
        output in_enable, in_start, in_current_assignment, in_clause_data, in_flag,
        input  out_clause_addr, out_coefficients_clause1, out_coefficients_clause2,
               out_current_assignment, out_busy, out_done, out_violations, out_all_sat
    );
endinterface

// File: rtl/clause_scheduler_popcount2.sv
// Number of violated clauses (0..2) in a checker flag pair; 1 = satisfied.
module clause_popcount2 (
    input  logic [1:0] flag_i,
    output logic [1:0] count_o
);
    assign count_o = {1'b0, ~flag_i[0]} + {1'b0, ~flag_i[1]};
endmodule

// File: rtl/clause_scheduler.sv
// Walks clause memory pair by pair, feeds the checker and counts violated clauses.
// Optional: CLAUSE_SCHEDULER_EARLY_EXIT_EN stops the sweep at the first violating pair.
module clause_scheduler
    import clause_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PAIRS = 2,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned CNT_W     = 3
) (
    input logic              in_clk,
    input logic              in_reset,
    clause_scheduler_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pair_q, pair_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     coef1_q, coef1_d, coef2_q, coef2_d;
    logic [AW-1:0]     asg_q, asg_d;
    logic              busy_q, busy_d, done_q, done_d, sat_q, sat_d;
    logic [CNT_W-1:0]  viol_q, viol_d;
    logic [1:0]        pop;
    logic              last_pair;

    clause_popcount2 u_pop (
        .flag_i  (bus.in_flag),
        .count_o (pop)
    );

    assign last_pair = (pair_q == ADDR_W'(NUM_PAIRS - 1));

    always_comb begin
        state_d = state_q;
        pair_d  = pair_q;
        cnt_d   = cnt_q;
        coef1_d = coef1_q;
        coef2_d = coef2_q;
        asg_d   = asg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        viol_d  = viol_q;
        sat_d   = sat_q;

        // busy drops as the done pulse ends, unless a new sweep starts right then
        if (done_q) busy_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_start) begin
                    asg_d   = bus.in_current_assignment;
                    pair_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_DRIVE;
            S_DRIVE: begin
                coef1_d = bus.in_clause_data[CW-1:0];
                coef2_d = bus.in_clause_data[2*CW-1:CW];
                state_d = S_EVAL;
            end
            S_EVAL: begin
                cnt_d = cnt_q + CNT_W'(pop);
`ifdef CLAUSE_SCHEDULER_EARLY_EXIT_EN
                if (last_pair || bus.in_flag != 2'b11) begin
`else
                if (last_pair) begin
`endif
                    state_d = S_DONE;
                end else begin
                    pair_d  = pair_q + ADDR_W'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                viol_d  = cnt_q;
                sat_d   = (cnt_q == '0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            state_q <= S_IDLE;
            pair_q  <= '0;
            cnt_q   <= '0;
            coef1_q <= '0;
            coef2_q <= '0;
            asg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            viol_q  <= '0;
            sat_q   <= 1'b0;
        end else if (bus.in_enable) begin
            state_q <= state_d;
            pair_q  <= pair_d;
            cnt_q   <= cnt_d;
            coef1_q <= coef1_d;
            coef2_q <= coef2_d;
            asg_q   <= asg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            viol_q  <= viol_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.out_clause_addr          = pair_q;
    assign bus.out_coefficients_clause1 = coef1_q;
    assign bus.out_coefficients_clause2 = coef2_q;
    assign bus.out_current_assignment   = asg_q;
    assign bus.out_busy                 = busy_q;
    assign bus.out_done                 = done_q;
    assign bus.out_violations           = viol_q;
    assign bus.out_all_sat              = sat_q;
endmodule

// File: tb/tb_clause_scheduler.sv
// Directed bench for clause_scheduler with a clause memory model, flag stub and per-cycle reference model.
module tb_clause_scheduler;
    import clause_scheduler_pkg::*;

    localparam int unsigned NP = 2;
`ifdef CLAUSE_SCHEDULER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clause_scheduler_if #(.ADDR_W(4), .CNT_W(3)) bus ();

    clause_scheduler #(.NUM_PAIRS(NP), .ADDR_W(4), .CNT_W(3)) dut (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (bus)
    );

    logic [47:0] mem  [NP];
    logic [1:0]  ftab [NP];
    logic [47:0] rd_q = '0;

    always @(posedge clk) rd_q <= mem[bus.out_clause_addr[0]];
    assign bus.in_clause_data = rd_q;
    assign bus.in_flag        = ftab[bus.out_clause_addr[0]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int zeros(input logic [1:0] f);
        return (f[0] ? 0 : 1) + (f[1] ? 0 : 1);
    endfunction

    // Reference model: counts enabled cycles since the accepted start and applies the sweep rules.
    bit          m_valid = 0, m_active = 0;
    int          m_t = 0, m_k = 0, m_done_at = 0, m_cnt = 0;
    logic [3:0]  e_addr = '0;
    logic [23:0] e_c1 = '0, e_c2 = '0;
    logic [15:0] e_asg = '0;
    logic        e_busy = 0, e_done = 0, e_sat = 0;
    logic [2:0]  e_viol = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 1; m_active = 0; m_t = 0; m_done_at = 0; m_cnt = 0;
            e_addr = '0; e_c1 = '0; e_c2 = '0; e_asg = '0;
            e_busy = 0; e_done = 0; e_viol = '0; e_sat = 0;
        end else if (m_valid && bus.in_enable) begin
            if (e_done) begin e_done = 0; e_busy = 0; end
            if (m_active) begin
                m_t++;
                if (m_done_at != 0 && m_t == m_done_at) begin
                    e_done = 1; e_viol = 3'(m_cnt); e_sat = (m_cnt == 0); m_active = 0;
                end else begin
                    m_k = (m_t - 1) / 3;
                    if (m_t == 3 * m_k + 2) {e_c2, e_c1} = mem[m_k];
                    if (m_t == 3 * m_k + 3) begin
                        m_cnt += zeros(ftab[m_k]);
                        if (m_k == NP - 1 || (EARLY && ftab[m_k] != 2'b11)) m_done_at = m_t + 1;
                        else e_addr = 4'(m_k + 1);
                    end
                end
            end else if (bus.in_start) begin
                m_active = 1; m_t = 0; m_done_at = 0; m_cnt = 0;
                e_asg = bus.in_current_assignment; e_busy = 1; e_addr = '0;
            end
        end
        #1;
        if (m_valid) begin
            check("addr",  64'(bus.out_clause_addr), 64'(e_addr));
            check("coef1", 64'(bus.out_coefficients_clause1), 64'(e_c1));
            check("coef2", 64'(bus.out_coefficients_clause2), 64'(e_c2));
            check("asg",   64'(bus.out_current_assignment), 64'(e_asg));
            check("busy",  64'(bus.out_busy), 64'(e_busy));
            check("done",  64'(bus.out_done), 64'(e_done));
            check("viol",  64'(bus.out_violations), 64'(e_viol));
            check("sat",   64'(bus.out_all_sat), 64'(e_sat));
        end
    end

    // Issues one start, then drives per-edge side stimulus; returns edges from acceptance to out_done.
    task automatic sweep(input logic [15:0] a, input int dup_at, input int stall_at,
                         input int stall_len, input int rst_at,
                         output int cyc, output bit seen, output logic [23:0] c1, output logic [23:0] c2);
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_current_assignment = a;
        @(negedge clk);
        bus.in_start = 1'b0;
        cyc = 0; seen = 0; c1 = '0; c2 = '0;
        while (cyc < 40 && !seen) begin
            bus.in_start  = (cyc + 1 == dup_at);
            bus.in_enable = !(cyc + 1 > stall_at && cyc + 1 <= stall_at + stall_len);
            rst           = !(cyc + 1 == rst_at);
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2) begin
                c1 = bus.out_coefficients_clause1;
                c2 = bus.out_coefficients_clause2;
            end
            seen = bus.out_done;
            @(negedge clk);
        end
        bus.in_start = 1'b0; bus.in_enable = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    int          cyc;
    bit          seen;
    logic [23:0] c1, c2;

    initial begin
        bus.in_enable = 1'b1;
        bus.in_start = 1'b0;
        bus.in_current_assignment = '0;
        mem[0] = 48'h010101_020101;
        mem[1] = 48'h030303_040404;
        ftab[0] = 2'b11; ftab[1] = 2'b11;

        repeat (2) @(negedge clk);
        check("rst_viol",  64'(bus.out_violations), 64'd0);
        check("rst_busy",  64'(bus.out_busy), 64'd0);
        check("rst_done",  64'(bus.out_done), 64'd0);
        check("rst_sat",   64'(bus.out_all_sat), 64'd0);
        check("rst_coef1", 64'(bus.out_coefficients_clause1), 64'd0);
        check("rst_asg",   64'(bus.out_current_assignment), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // all satisfied
        sweep(16'h0101, 0, 0, 0, 0, cyc, seen, c1, c2);
        check("t1_cycles", 64'(cyc), 64'd7);
        check("t1_viol",   64'(bus.out_violations), 64'd0);
        check("t1_sat",    64'(bus.out_all_sat), 64'd1);
        check("t1_asg",    64'(bus.out_current_assignment), 64'h0101);
        check("t1_busy",   64'(bus.out_busy), 64'd0);

        // mixed violations, coefficient routing
        ftab[0] = 2'b01; ftab[1] = 2'b00;
        sweep(16'h1234, 0, 0, 0, 0, cyc, seen, c1, c2);
        check("t2_coef1", 64'(c1), 64'h020101);
        check("t2_coef2", 64'(c2), 64'h010101);
        check("t2_cycles", 64'(cyc), EARLY ? 64'd4 : 64'd7);
        check("t2_viol",   64'(bus.out_violations), EARLY ? 64'd1 : 64'd3);
        check("t2_sat",    64'(bus.out_all_sat), 64'd0);

        // start while busy is ignored
        ftab[0] = 2'b11; ftab[1] = 2'b11;
        sweep(16'h0202, 3, 0, 0, 0, cyc, seen, c1, c2);
        check("t3_cycles", 64'(cyc), 64'd7);
        check("t3_viol",   64'(bus.out_violations), 64'd0);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_done) seen = 1;
        end
        check("t3_extra_done", 64'(seen), 64'd0);

        // enable stall of 4 cycles
        ftab[0] = 2'b11; ftab[1] = 2'b01;
        sweep(16'h0303, 0, 3, 4, 0, cyc, seen, c1, c2);
        check("t4_cycles", 64'(cyc), 64'd11);
        check("t4_viol",   64'(bus.out_violations), 64'd1);

        // reset while in DRIVE aborts the sweep
        sweep(16'hBEEF, 0, 0, 0, 2, cyc, seen, c1, c2);
        check("t5_no_done", 64'(seen), 64'd0);
        check("t5_viol",    64'(bus.out_violations), 64'd0);
        check("t5_asg",     64'(bus.out_current_assignment), 64'd0);
        check("t5_coef1",   64'(bus.out_coefficients_clause1), 64'd0);
        ftab[0] = 2'b11; ftab[1] = 2'b11;
        sweep(16'h0404, 0, 0, 0, 0, cyc, seen, c1, c2);
        check("t5_cycles", 64'(cyc), 64'd7);
        check("t5_sat",    64'(bus.out_all_sat), 64'd1);

        // first-pair violation: early exit when enabled
        ftab[0] = 2'b10; ftab[1] = 2'b11;
        sweep(16'h0505, 0, 0, 0, 0, cyc, seen, c1, c2);
        check("t6_cycles", 64'(cyc), EARLY ? 64'd4 : 64'd7);
        check("t6_viol",   64'(bus.out_violations), 64'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
